bcd_seq_convert: RTL and testbench
==================================

Name: bcd_seq_convert

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Generalises the team's fixed 4-bit BCD decode to any binary width and digit count, with a start/busy/done handshake.
- Feeds the multi-digit display path: one conversion per request, result held until the next conversion completes.

Parameters:
- BIN_W, 8, width of the binary input. Legal range is 1 to 32.
- DIGITS, 3, number of BCD digits produced. Must satisfy 10**DIGITS > 2**BIN_W - 1; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when ready.
- bin_in  input  BIN_W  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while the conversion is shifting.
- done  output  1  one-cycle pulse; bcd_out is valid and new in that cycle.
- bcd_out  output  4*DIGITS  packed BCD result. Digit 0 (ones) occupies bits [3:0].

Behaviour:
- Reset: on a clk edge with rst=1, the block enters IDLE and clears all outputs:
  - busy=0, done=0, bcd_out=0.
  - The internal scratch register and the shift counter are also cleared.
- rst has priority over every other input. Reset during SHIFT aborts the conversion and produces no done pulse.
- FSM states:
  - IDLE.
  - SHIFT.
  - DONE. This state lasts exactly one cycle.
- ready = (state==IDLE) or (state==DONE).
- Accept: on an edge with ready=1 and start=1:
  - Latch bin_in into the binary shift register.
  - Clear the BCD scratch register.
  - Load count=BIN_W.
  - Go to SHIFT.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3, all digits in parallel.
  - Then {scratch, binreg} shifts left by 1.
  - count decrements.
  - On the edge where count goes 1 to 0, the fully shifted scratch value is written to bcd_out and the state goes to DONE.
- DONE:
  - done=1 for this cycle only.
  - Next state is SHIFT if start=1 (back-to-back accept, new bin_in latched). Otherwise IDLE.
- busy = (state==SHIFT). Outputs are registered or decoded from the registered state; there is no combinational path from start to busy.
- Latency: start is sampled at edge E0. The done pulse falls in the cycle after edge E(BIN_W), i.e. exactly BIN_W cycles after acceptance. Throughput is one result per BIN_W+1 cycles.
- start=1 while busy=1 is ignored. No queueing, no error indication.
- bin_in changes after acceptance have no effect.
- bcd_out holds the last result through IDLE and SHIFT. It changes only on the edge entering DONE, or on reset.
- Arithmetic:
  - The add-3 correction operates on 4-bit digits and never carries between digits.
  - The scratch register is 4*DIGITS bits wide.
  - Bits shifted out of the top digit are discarded; the DIGITS legality rule guarantees these are always 0.
- Input 0 produces bcd_out=0 with the same full latency. There is no early exit.

Optional Feature:
- Macro: BCD_ONEHOT_EN.
- Defined:
  - Adds output port ones_onehot[9:0], with bit k = (bcd_out[3:0]==k), registered alongside bcd_out.
  - Reset value is 10'b0000000001.
  - Exactly one bit is high at all times after reset.
  - This is the per-digit decode the display path needs for the ones digit.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - ADD3_THRESH=4'd5.
  - The FSM state enum {IDLE, SHIFT, DONE}.
  - A function computing the minimum DIGITS for a given BIN_W, used by the elaboration check.
- Sub-module bcd_add3: 4-bit combinational digit corrector (in >= 5 ? in+3 : in), instantiated DIGITS times by generate.
- FSM, counter, and shift register stay in the top module.

Test Plan:
- Default parameters, bin_in=8'd255, start pulse:
  - busy high for 8 cycles.
  - done pulse at E0+8.
  - bcd_out=12'h255.
- Sweep bin_in=0..255 with back-to-back start held high:
  - Every result matches the decimal reference, e.g. 0 gives 12'h000, 99 gives 12'h099, 170 gives 12'h170.
  - Each done is spaced exactly 9 cycles apart.
- Start pulsed during SHIFT with a different bin_in (255 in flight, 7 offered):
  - The second request is ignored.
  - Result is 12'h255.
  - Only one done pulse appears.
- rst asserted at cycle 4 of a conversion of 200:
  - Next cycle shows busy=0 and bcd_out=0.
  - No done pulse appears.
  - A fresh start with 42 yields 12'h042.
- BIN_W=16, DIGITS=5, bin_in=65535:
  - done after 16 cycles.
  - bcd_out=20'h65535.
- BCD_ONEHOT_EN defined, bin_in=37:
  - ones_onehot=10'b0010000000.
  - After reset, ones_onehot=10'b0000000001.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and legality helper for the sequential BCD converter.
// Used by bcd_add3 and bcd_seq_convert (optional port macro: BCD_ONEHOT_EN).
package bcd_pkg;

    localparam int        BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count whose decimal range covers every BIN_W-bit value.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << bin_w) - 64'd1;
        pow10   = 64'd10;
        d       = 1;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                d     = d + 1;
                pow10 = pow10 * 64'd10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more, no carry out.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done handshake.
// Define BCD_ONEHOT_EN to add the registered one-hot decode of the ones digit.
module bcd_seq_convert
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
`ifdef BCD_ONEHOT_EN
    ,
    output logic [9:0]                    ones_onehot
`endif
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bcd_seq_convert: BIN_W=%0d outside 1..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bcd_seq_convert: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [BIN_W-1:0]   bin_q,     bin_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   bcd_q,     bcd_d;

    logic [SCR_W-1:0]   corr;
    logic [SCR_W-1:0]   scr_shift;
    logic               shift_out_unused;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The top scratch bit falls off; the DIGITS legality rule keeps it zero.
    assign {shift_out_unused, scr_shift} = {corr, bin_q[BIN_W-1]};

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;

        case (state_q)
            SHIFT: begin
                scratch_d = scr_shift;
                bin_d     = bin_q << 1;
                count_d   = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE are both ready to accept a new operand.
                state_d = IDLE;
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;

`ifdef BCD_ONEHOT_EN
    logic [9:0] onehot_q, onehot_d;

    assign onehot_d = 10'd1 << bcd_d[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= 10'd1;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign ones_onehot = onehot_q;
`else
    // Without the decode option only the packed BCD result is exported.
`endif

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Self-checking bench: decimal reference model, per-cycle compare, directed and random stimulus.
module tb_bcd_seq_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    logic        start16;
    logic [15:0] bin16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;

`ifdef BCD_ONEHOT_EN
    logic [9:0]  ones_onehot;
    logic [9:0]  ones_onehot16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seq_convert #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BCD_ONEHOT_EN
        ,
        .ones_onehot (ones_onehot)
`endif
    );

    bcd_seq_convert #(.BIN_W(16), .DIGITS(5)) u_dut16 (
        .clk     (clk),
        .rst     (rst),
        .start   (start16),
        .bin_in  (bin16),
        .busy    (busy16),
        .done    (done16),
        .bcd_out (bcd16)
`ifdef BCD_ONEHOT_EN
        ,
        .ones_onehot (ones_onehot16)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Decimal digits by repeated division: digit i in bits [4i+3:4i].
    function automatic logic [79:0] to_bcd(input longint unsigned v);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 20; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: a conversion occupies exactly 8 shifting cycles, then one done cycle.
    int          m_rem   = 0;
    logic        m_done  = 1'b0;
    logic [11:0] m_bcd   = '0;
    logic [7:0]  m_val   = '0;
    logic [9:0]  m_oh    = 10'd1;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem   <= 0;
            m_done  <= 1'b0;
            m_bcd   <= '0;
            m_oh    <= 10'd1;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_bcd  <= 12'(to_bcd(m_val));
                    m_oh   <= 10'd1 << (m_val % 10);
                end else begin
                    m_done <= 1'b0;
                end
            end else begin
                m_done <= 1'b0;
                if (start) begin
                    m_val <= bin_in;
                    m_rem <= 8;
                end
            end
        end
    end

    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    logic        sweep_on = 1'b0;
    logic [11:0] last_bcd = '0;
    logic [11:0] res_arr [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_rem != 0));
            check("done", 64'(done), 64'(m_done));
            check("bcd_out", 64'(bcd_out), 64'(m_bcd));
`ifdef BCD_ONEHOT_EN
            check("ones_onehot", 64'(ones_onehot), 64'(m_oh));
`endif
            if (done) begin
                done_cnt++;
                last_bcd = bcd_out;
                if (sweep_on) begin
                    if (last_done_cyc >= 0) check("done_spacing", 64'(cyc - last_done_cyc), 64'd9);
                    last_done_cyc = cyc;
                    res_arr[m_val] = bcd_out;
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (m_rem == 0) return;
            @(negedge clk);
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_one(input logic [7:0] v, output int lat, output int bcy);
        wait_ready();
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        lat = 0;
        bcy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (busy) bcy++;
            @(posedge clk);
            lat++;
        end
        check("run_done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int lat;
        int bcy;
        int d0;
        logic [15:0] v16;

        rst = 1'b1; start = 1'b0; bin_in = '0; start16 = 1'b0; bin16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd", 64'(bcd_out), 64'd0);
`ifdef BCD_ONEHOT_EN
        check("reset_onehot", 64'(ones_onehot), 64'b0000000001);
`endif
        rst = 1'b0;

        // Single conversion of 255.
        run_one(8'd255, lat, bcy);
        check("lat_255", 64'(lat), 64'd8);
        check("busy_cycles_255", 64'(bcy), 64'd8);
        check("bcd_255", 64'(bcd_out), 64'h255);

        // Back-to-back sweep of every 8-bit value with start held high.
        wait_ready();
        sweep_on = 1'b1;
        last_done_cyc = -1;
        for (int v = 0; v < 256; v++) begin
            bin_in = 8'(v);
            start  = 1'b1;
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        wait_ready();
        @(negedge clk);
        sweep_on = 1'b0;
        check("sweep_0", 64'(res_arr[0]), 64'h000);
        check("sweep_99", 64'(res_arr[99]), 64'h099);
        check("sweep_170", 64'(res_arr[170]), 64'h170);
        check("sweep_255", 64'(res_arr[255]), 64'h255);

        // Start offered mid-conversion must be ignored.
        wait_ready();
        @(negedge clk);
        d0 = done_cnt;
        bin_in = 8'd255;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin_in = 8'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("ignored_start_dones", 64'(done_cnt - d0), 64'd1);
        check("ignored_start_bcd", 64'(last_bcd), 64'h255);

        // Reset on the fourth edge of a conversion of 200 aborts it.
        wait_ready();
        @(negedge clk);
        d0 = done_cnt;
        bin_in = 8'd200;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bcd", 64'(bcd_out), 64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_one(8'd42, lat, bcy);
        check("after_abort_42", 64'(bcd_out), 64'h042);

`ifdef BCD_ONEHOT_EN
        run_one(8'd37, lat, bcy);
        check("onehot_37", 64'(ones_onehot), 64'b0010000000);
`endif

        // Randomised traffic with occasional resets, checked every cycle by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            bin_in = 8'($urandom);
            rst    = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;

        // Wide instance: 16-bit operand, five digits.
        for (int k = 0; k < 4; k++) begin
            v16 = (k == 0) ? 16'hFFFF : 16'($urandom);
            @(negedge clk);
            bin16   = v16;
            start16 = 1'b1;
            @(posedge clk);
            lat = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                start16 = 1'b0;
                bin16   = 16'($urandom);
                if (done16) break;
                @(posedge clk);
                lat++;
            end
            check("w16_done_seen", 64'(done16), 64'd1);
            check("w16_latency", 64'(lat), 64'd16);
            check("w16_bcd", 64'(bcd16), 64'(20'(to_bcd(64'(v16)))));
            if (k == 0) check("w16_65535", 64'(bcd16), 64'h65535);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
